// File: rtl/uart_receiver_pkg.sv
// Shared constants and helpers for the UART receiver; the bit-time formula
// matches the transmitter so both ends agree on symbol length.
package uart_receiver_pkg;

    function automatic int unsigned symbol_edge_time(input int unsigned clock_freq,
                                                     input int unsigned baud_rate);
        return clock_freq / baud_rate;
    endfunction

    function automatic int unsigned sample_time(input int unsigned clock_freq,
                                                input int unsigned baud_rate);
        return symbol_edge_time(clock_freq, baud_rate) / 2;
    endfunction

    function automatic int unsigned log2_ceil(input int unsigned value);
        return $clog2(value);
    endfunction

endpackage

// File: rtl/uart_receiver_sync_2ff.sv
// Two-flop synchroniser for an asynchronous input pin; both stages reset to
// RESET_VALUE so an idle-high line does not look like an edge out of reset.
module sync_2ff #(
    parameter logic RESET_VALUE = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic s1_q, s1_d;
    logic s2_q, s2_d;

    // Next-state for the two synchroniser stages.
    always_comb begin
        s1_d = d;
        s2_d = s1_q;
    end

    // Synchroniser stage registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_q <= RESET_VALUE;
            s2_q <= RESET_VALUE;
        end else begin
            s1_q <= s1_d;
            s2_q <= s2_d;
        end
    end

    assign q = s2_q;

endmodule

// File: rtl/uart_receiver.sv
// 8N1-style UART receiver: oversampled-by-counter frame decoder with a
// single-word valid/ready output buffer, framing-error pulse and sticky overrun.
module uart_receiver
    import uart_receiver_pkg::*;
#(
    parameter int unsigned CLOCK_FREQ = 33_000_000,
    parameter int unsigned BAUD_RATE  = 115_200,
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  serial_in,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  data_out_valid,
    input  logic                  data_out_ready,
    output logic                  framing_error,
    output logic                  overrun
);

    localparam int unsigned SYMBOL_EDGE_TIME = symbol_edge_time(CLOCK_FREQ, BAUD_RATE);
    localparam int unsigned SAMPLE_TIME      = sample_time(CLOCK_FREQ, BAUD_RATE);
    localparam int unsigned CNT_W            = log2_ceil(SYMBOL_EDGE_TIME);
    localparam int unsigned BIT_W            = log2_ceil(DATA_WIDTH) + 1;

    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(SAMPLE_TIME - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(SYMBOL_EDGE_TIME - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        STOP      = 3'd3,
        WAIT_HIGH = 3'd4
    } state_e;

    logic                  rx;
    state_e                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [BIT_W-1:0]      bit_cnt_q, bit_cnt_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  valid_q, valid_d;
    logic                  fe_q, fe_d;
    logic                  ovr_q, ovr_d;
    logic                  accept_s;
    logic                  deliver_s;

    sync_2ff #(
        .RESET_VALUE(1'b1)
    ) u_sync (
        .clk  (clk),
        .reset(reset),
        .d    (serial_in),
        .q    (rx)
    );

    // Frame decoder and output-buffer next-state logic.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q + CNT_W'(1);
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        data_d    = data_q;
        valid_d   = valid_q;
        fe_d      = 1'b0;
        ovr_d     = ovr_q;
        deliver_s = 1'b0;
        accept_s  = valid_q && data_out_ready;

        if (accept_s) begin
            valid_d = 1'b0;
        end else begin
            valid_d = valid_q;
        end

        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (!rx) begin
                    state_d = START;
                end else begin
                    state_d = IDLE;
                end
            end
            START: begin
                if (cnt_q == CNT_HALF) begin
                    cnt_d = '0;
                    if (rx) begin
                        state_d = IDLE;
                    end else begin
                        state_d   = DATA;
                        bit_cnt_d = '0;
                    end
                end else begin
                    state_d = START;
                end
            end
            DATA: begin
                if (cnt_q == CNT_FULL) begin
                    cnt_d     = '0;
                    shift_d   = {rx, shift_q[DATA_WIDTH-1:1]};
                    bit_cnt_d = bit_cnt_q + BIT_W'(1);
                    if (bit_cnt_q == BIT_LAST) begin
                        state_d = STOP;
                    end else begin
                        state_d = DATA;
                    end
                end else begin
                    state_d = DATA;
                end
            end
            STOP: begin
                if (cnt_q == CNT_FULL) begin
                    cnt_d = '0;
                    if (rx) begin
                        deliver_s = 1'b1;
                        state_d   = IDLE;
                    end else begin
                        fe_d    = 1'b1;
                        state_d = WAIT_HIGH;
                    end
                end else begin
                    state_d = STOP;
                end
            end
            WAIT_HIGH: begin
                // Hold off a break condition until the line returns high.
                cnt_d = '0;
                if (rx) begin
                    state_d = IDLE;
                end else begin
                    state_d = WAIT_HIGH;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase

        if (deliver_s) begin
            if (!valid_q || accept_s) begin
                data_d  = shift_q;
                valid_d = 1'b1;
            end else begin
                ovr_d = 1'b1;
            end
        end else begin
            data_d = data_q;
        end
    end

    // State, datapath and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            fe_q      <= 1'b0;
            ovr_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            fe_q      <= fe_d;
            ovr_q     <= ovr_d;
        end
    end

    assign data_out       = data_q;
    assign data_out_valid = valid_q;
    assign framing_error  = fe_q;
    assign overrun        = ovr_q;

endmodule

// File: doc/uart_receiver.md
Name: uart_receiver

Overview:
Serial-to-parallel UART receiver: 8N1 framing (1 start, DATA_WIDTH data bits LSB-first, 1 stop), idle-high line.
Deserialises `serial_in` into DATA_WIDTH-bit words and presents them on a valid/ready output port.
Sits on the FPGA RX pin, feeding the command/data path. Pairs with the existing UART transmitter; parameters are identical so both ends agree on bit time.

Parameters:
CLOCK_FREQ, 33_000_000, system clock frequency in Hz
BAUD_RATE, 115_200, line bit rate in baud
DATA_WIDTH, 8, data bits per frame

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
serial_in  input  1  asynchronous RX line, idle high
data_out  output  DATA_WIDTH  received word; stable while data_out_valid=1
data_out_valid  output  1  word available
data_out_ready  input  1  consumer accepts word when valid&&ready at posedge clk
framing_error  output  1  one-cycle pulse: stop bit sampled low
overrun  output  1  sticky: complete word dropped because buffer was full

Behaviour:
- Constants: SYMBOL_EDGE_TIME = CLOCK_FREQ/BAUD_RATE (integer divide; 286 at defaults). SAMPLE_TIME = SYMBOL_EDGE_TIME/2 (143).
- Counter widths: clock counter is `log2(SYMBOL_EDGE_TIME) bits; bit counter is `log2(DATA_WIDTH)+1 bits.
- serial_in passes through a 2-flop synchroniser; both flops reset to 1. All decisions use the synchronised value `rx`.
- Clock counter clears on every state entry, increments otherwise.
- States:
  - IDLE: if rx==0, go to START.
  - START: at counter==SAMPLE_TIME-1 (mid start bit):
    - rx==1 → false start, go to IDLE, no outputs change.
    - rx==0 → go to DATA, bit count=0.
  - DATA: at counter==SYMBOL_EDGE_TIME-1 (mid data bit), shift rx into the shift register MSB, shifting right, so the word is LSB-first. Increment bit count. After DATA_WIDTH samples, go to STOP.
  - STOP: at counter==SYMBOL_EDGE_TIME-1:
    - rx==1 → deliver word, go to IDLE.
    - rx==0 → pulse framing_error for 1 cycle, discard word, go to WAIT_HIGH.
  - WAIT_HIGH: remain until rx==1, then go to IDLE. This prevents a break condition from being parsed as back-to-back frames.
- Delivery (cycle after stop sample):
  - Buffer empty, or valid&&ready in that same cycle → data_out loaded, data_out_valid=1, no overrun.
  - Buffer full and not accepted → new word dropped, data_out unchanged, overrun set to 1.
- data_out_valid clears on valid&&ready with no simultaneous delivery. Valid held until accepted; data_out never changes while valid=1 unless the word is consumed that cycle.
- overrun clears only on reset.
- Latency: data_out_valid rises 1 clk after the mid-stop-bit sample, i.e. ≈ 2 + (DATA_WIDTH+1.5)·SYMBOL_EDGE_TIME clks after the falling start edge at the pin.
- Reset (any time, including mid-frame):
  - state=IDLE, counters=0, shift register=0.
  - data_out=0, data_out_valid=0, framing_error=0, overrun=0, synchroniser=1.
  - A partial frame in flight is discarded; receiver resynchronises on the next falling edge after reset deasserts.
- A falling edge in STOP/DATA is not a new start; only IDLE detects starts. The first start edge after a stop bit is detected within 1 clk of entering IDLE.

Decomposition:
- Shared header (existing util include): `log2 macro only.
- State encodings (IDLE, START, DATA, STOP, WAIT_HIGH) are localparams inside the module. SYMBOL_EDGE_TIME/SAMPLE_TIME are localparams derived from parameters, same formula as the transmitter.
- One natural sub-module: sync_2ff, a 2-flop synchroniser with parameterised reset value 1. It is reusable for other async pins.

Test Plan:
- Frame 0xA5 at 115200 baud, data_out_ready=1 → data_out=0xA5, data_out_valid high exactly 1 cycle, framing_error=0, overrun=0.
- 100-clk low glitch on idle line (< SAMPLE_TIME) → no valid, no framing_error, state back to IDLE; following 0x3C frame received correctly.
- Frame 0x5A with stop bit driven low → framing_error 1-cycle pulse, no valid. Line held low 3 bit times then high; next frame 0x11 → data_out=0x11 valid.
- data_out_ready=0, frames 0x01 then 0x02 → data_out stays 0x01, valid=1, overrun=1 after second stop. Assert ready → valid drops next cycle, overrun stays 1.
- Back-to-back frames 0x00, 0xFF (no idle gap), ready=1 → two valid pulses with 0x00 then 0xFF. Also valid&&ready coincident with second delivery → no overrun.
- Reset asserted mid-DATA of a 0xC3 frame, released before the next frame, then frame 0x7E sent → all outputs 0 during reset, no word from the partial frame, data_out=0x7E.
